// File: rtl/win_checker.sv
// win_checker: Connect Four game-logic responder.
// On each accepted logic_go it captures one column into a shadow board. It
// then walks outward from the new disc, one cell per cycle, in four
// directions, and reports win or draw with a one-cycle done pulse.
// Optional feature: define WIN_CHECK_DRAW_EN to report a full board with no
// win as a draw.
module win_checker #(
    parameter int unsigned COLS    = 7,
    parameter int unsigned ROWS    = 6,
    parameter int unsigned WIN_LEN = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            logic_go,
    input  logic            logic_reset,
    input  logic [2:0]      col_addr,
    input  logic [ROWS-1:0] onoff_col,
    input  logic [ROWS-1:0] player_col,
    output logic            busy,
    output logic            done,
    output logic            logic_result,
    output logic            winner,
    output logic [1:0]      win_dir,
    output logic            draw
);

    // Shadow board is always 8x8 so that 3-bit coordinates index it directly.
    localparam int unsigned MAXD = 8;

    // NEXT_DIR is resolved inside the SCAN_NEG exit and has no state of its own.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOCATE,
        S_SCAN_POS,
        S_SCAN_NEG,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [MAXD-1:0]   r_onoff  [MAXD];
    logic [MAXD-1:0]   r_player [MAXD];
    logic [2:0]        r_col;
    logic [2:0]        r_row;
    logic              r_p;
    logic [3:0]        r_cnt;
    logic [2:0]        r_k;
    logic [1:0]        r_dir;
    logic              r_busy;
    logic              r_done;
    logic              r_result;
    logic              r_winner;
    logic [1:0]        r_win_dir;
    logic              r_draw;

    state_t            w_state_nxt;
    logic [2:0]        w_col_nxt;
    logic [2:0]        w_row_nxt;
    logic              w_p_nxt;
    logic [3:0]        w_cnt_nxt;
    logic [2:0]        w_k_nxt;
    logic [1:0]        w_dir_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_result_nxt;
    logic              w_winner_nxt;
    logic [1:0]        w_win_dir_nxt;
    logic              w_draw_nxt;
    logic              w_wr;
    logic              w_clr;

    logic signed [4:0] w_step;
    logic signed [4:0] w_dc;
    logic signed [4:0] w_dr;
    logic signed [4:0] w_cc;
    logic signed [4:0] w_rr;
    logic              w_inb;
    logic              w_hit;
    logic [3:0]        w_cnt_inc;
    logic              w_win_step;
    logic              w_last_k;
    logic [2:0]        w_top_row;
    logic              w_top_p;

    assign busy         = r_busy;
    assign done         = r_done;
    assign logic_result = r_result;
    assign winner       = r_winner;
    assign win_dir      = r_win_dir;
    assign draw         = r_draw;

    // Coordinates of the cell under examination; negative values are caught by the sign bit.
    always_comb begin
        w_step = $signed({2'b00, r_k});
        if (r_state == S_SCAN_NEG) begin
            w_step = -w_step;
        end
        w_dc = '0;
        w_dr = '0;
        case (r_dir)
            2'd0:    w_dc = w_step;
            2'd1:    w_dr = w_step;
            2'd2:    begin w_dc = w_step; w_dr = w_step;  end
            default: begin w_dc = w_step; w_dr = -w_step; end
        endcase
        w_cc  = $signed({2'b00, r_col}) + w_dc;
        w_rr  = $signed({2'b00, r_row}) + w_dr;
        w_inb = !w_cc[4] && !w_rr[4] &&
                (w_cc[3:0] < 4'(COLS)) && (w_rr[3:0] < 4'(ROWS));
        w_hit = w_inb && r_onoff[w_cc[2:0]][w_rr[2:0]] &&
                (r_player[w_cc[2:0]][w_rr[2:0]] == r_p);
    end

    assign w_cnt_inc  = r_cnt + 4'd1;
    assign w_win_step = w_hit && (w_cnt_inc == 4'(WIN_LEN));
    assign w_last_k   = (r_k == 3'(WIN_LEN - 1));

    // Highest occupied row of the captured column, i.e. the new disc.
    always_comb begin
        w_top_row = '0;
        for (int i = 0; i < int'(ROWS); i++) begin
            if (r_onoff[r_col][3'(i)]) begin
                w_top_row = 3'(i);
            end
        end
        w_top_p = r_player[r_col][w_top_row];
    end

`ifdef WIN_CHECK_DRAW_EN
    logic w_full;

    // Every playable cell occupied.
    always_comb begin
        w_full = 1'b1;
        for (int c = 0; c < int'(COLS); c++) begin
            for (int r = 0; r < int'(ROWS); r++) begin
                if (!r_onoff[3'(c)][3'(r)]) begin
                    w_full = 1'b0;
                end
            end
        end
    end
`endif

    // Next-state and registered-output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = r_col;
        w_row_nxt     = r_row;
        w_p_nxt       = r_p;
        w_cnt_nxt     = r_cnt;
        w_k_nxt       = r_k;
        w_dir_nxt     = r_dir;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_result_nxt  = r_result;
        w_winner_nxt  = r_winner;
        w_win_dir_nxt = r_win_dir;
        w_draw_nxt    = r_draw;
        w_wr          = 1'b0;
        w_clr         = 1'b0;

        if (logic_reset) begin
            w_clr         = 1'b1;
            w_state_nxt   = S_IDLE;
            w_cnt_nxt     = '0;
            w_k_nxt       = '0;
            w_dir_nxt     = '0;
            w_result_nxt  = 1'b0;
            w_winner_nxt  = 1'b0;
            w_win_dir_nxt = '0;
            w_draw_nxt    = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (logic_go) begin
                        w_result_nxt  = 1'b0;
                        w_winner_nxt  = 1'b0;
                        w_win_dir_nxt = '0;
                        w_draw_nxt    = 1'b0;
                        if (({1'b0, col_addr} < 4'(COLS)) && (onoff_col != '0)) begin
                            w_wr        = 1'b1;
                            w_col_nxt   = col_addr;
                            w_busy_nxt  = 1'b1;
                            w_state_nxt = S_LOCATE;
                        end else begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_LOCATE: begin
                    w_row_nxt   = w_top_row;
                    w_p_nxt     = w_top_p;
                    w_cnt_nxt   = 4'd1;
                    w_k_nxt     = 3'd1;
                    w_dir_nxt   = 2'd0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_SCAN_POS;
                end
                S_SCAN_POS, S_SCAN_NEG: begin
                    w_busy_nxt = 1'b1;
                    if (w_win_step) begin
                        w_busy_nxt    = 1'b0;
                        w_done_nxt    = 1'b1;
                        w_state_nxt   = S_DONE;
                        w_result_nxt  = 1'b1;
                        w_winner_nxt  = r_p;
                        w_win_dir_nxt = r_dir;
                        w_draw_nxt    = 1'b0;
                    end else if (w_hit && !w_last_k) begin
                        w_cnt_nxt = w_cnt_inc;
                        w_k_nxt   = r_k + 3'd1;
                    end else if (r_state == S_SCAN_POS) begin
                        // Positive half ends; count carries into the negative half.
                        if (w_hit) begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                        w_k_nxt     = 3'd1;
                        w_state_nxt = S_SCAN_NEG;
                    end else if (r_dir == 2'd3) begin
                        // All four directions exhausted with no win.
                        w_busy_nxt    = 1'b0;
                        w_done_nxt    = 1'b1;
                        w_state_nxt   = S_DONE;
                        w_winner_nxt  = 1'b0;
                        w_win_dir_nxt = '0;
`ifdef WIN_CHECK_DRAW_EN
                        w_result_nxt  = w_full;
                        w_draw_nxt    = w_full;
`else
                        w_result_nxt  = 1'b0;
                        w_draw_nxt    = 1'b0;
`endif
                    end else begin
                        w_dir_nxt   = r_dir + 2'd1;
                        w_cnt_nxt   = 4'd1;
                        w_k_nxt     = 3'd1;
                        w_state_nxt = S_SCAN_POS;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, scan context and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_p       <= 1'b0;
            r_cnt     <= '0;
            r_k       <= '0;
            r_dir     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= 1'b0;
            r_winner  <= 1'b0;
            r_win_dir <= '0;
            r_draw    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_col     <= w_col_nxt;
            r_row     <= w_row_nxt;
            r_p       <= w_p_nxt;
            r_cnt     <= w_cnt_nxt;
            r_k       <= w_k_nxt;
            r_dir     <= w_dir_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_result  <= w_result_nxt;
            r_winner  <= w_winner_nxt;
            r_win_dir <= w_win_dir_nxt;
            r_draw    <= w_draw_nxt;
        end
    end

    // Shadow board: cleared on either reset, one column written per accepted go.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < int'(MAXD); c++) begin
                r_onoff[c]  <= '0;
                r_player[c] <= '0;
            end
        end else if (w_clr) begin
            for (int c = 0; c < int'(MAXD); c++) begin
                r_onoff[c]  <= '0;
                r_player[c] <= '0;
            end
        end else if (w_wr) begin
            r_onoff[col_addr]  <= MAXD'(onoff_col);
            r_player[col_addr] <= MAXD'(player_col);
        end
    end

endmodule

// File: tb/tb_win_checker.sv
// Bench for win_checker: a line-counting board model predicts result, winner,
// direction and completion latency; a compare process checks every cycle.
module tb_win_checker;

    localparam int unsigned COLS    = 7;
    localparam int unsigned ROWS    = 6;
    localparam int unsigned WIN_LEN = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            logic_go = 1'b0;
    logic            logic_reset = 1'b0;
    logic [2:0]      col_addr = '0;
    logic [ROWS-1:0] onoff_col = '0;
    logic [ROWS-1:0] player_col = '0;
    logic            busy;
    logic            done;
    logic            logic_result;
    logic            winner;
    logic [1:0]      win_dir;
    logic            draw;

    win_checker #(.COLS(COLS), .ROWS(ROWS), .WIN_LEN(WIN_LEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .logic_go     (logic_go),
        .logic_reset  (logic_reset),
        .col_addr     (col_addr),
        .onoff_col    (onoff_col),
        .player_col   (player_col),
        .busy         (busy),
        .done         (done),
        .logic_result (logic_result),
        .winner       (winner),
        .win_dir      (win_dir),
        .draw         (draw)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_on [8][8];
    bit m_pl [8][8];
    int m_left = 0;
    bit m_busy = 0, m_done = 0, m_res = 0, m_win = 0, m_draw = 0;
    int m_dir = 0;
    bit p_res = 0, p_win = 0, p_draw = 0;
    int p_dir = 0;

    function automatic bit cell_is(int c, int r, int p);
        if (c < 0 || r < 0 || c >= int'(COLS) || r >= int'(ROWS)) return 1'b0;
        return m_on[c][r] && (int'(m_pl[c][r]) == p);
    endfunction

    function automatic int run_len(int c, int r, int dc, int dr, int p);
        int n = 0;
        while (n < int'(WIN_LEN) - 1 && cell_is(c + (n + 1) * dc, r + (n + 1) * dr, p)) n++;
        return n;
    endfunction

    function automatic bit board_full();
        for (int c = 0; c < int'(COLS); c++)
            for (int r = 0; r < int'(ROWS); r++)
                if (!m_on[c][r]) return 1'b0;
        return 1'b1;
    endfunction

    // Examinations spent and outcome: each half-line costs its run plus the failing probe.
    function automatic void evaluate(input int c, input int r, input int p,
                                     output int e, output bit win, output int dir);
        int dcs[4] = '{1, 0, 1, 1};
        int drs[4] = '{0, 1, 1, -1};
        int pos, neg, need;
        e = 0; win = 0; dir = 0;
        for (int d = 0; d < 4; d++) begin
            pos = run_len(c, r, dcs[d], drs[d], p);
            if (pos >= int'(WIN_LEN) - 1) begin
                e += int'(WIN_LEN) - 1; win = 1; dir = d; return;
            end
            e += pos + 1;
            need = int'(WIN_LEN) - 1 - pos;
            neg = run_len(c, r, -dcs[d], -drs[d], p);
            if (neg >= need) begin
                e += need; win = 1; dir = d; return;
            end
            e += neg + 1;
        end
    endfunction

    initial begin
        int e, top, dir;
        bit w;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset || logic_reset) begin
                for (int c = 0; c < 8; c++)
                    for (int r = 0; r < 8; r++) begin m_on[c][r] = 0; m_pl[c][r] = 0; end
                m_busy = 0; m_done = 0; m_left = 0;
                m_res = 0; m_win = 0; m_dir = 0; m_draw = 0;
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1;
                    m_res = p_res; m_win = p_win; m_dir = p_dir; m_draw = p_draw;
                end
            end else if (m_done) begin
                m_done = 0;
            end else if (logic_go) begin
                m_res = 0; m_win = 0; m_dir = 0; m_draw = 0;
                if (int'(col_addr) < int'(COLS) && onoff_col != '0) begin
                    top = 0;
                    for (int r = 0; r < int'(ROWS); r++) begin
                        m_on[col_addr][r] = onoff_col[r];
                        m_pl[col_addr][r] = player_col[r];
                        if (onoff_col[r]) top = r;
                    end
                    evaluate(int'(col_addr), top, int'(player_col[top]), e, w, dir);
                    p_res = w; p_win = w ? player_col[top] : 1'b0; p_dir = w ? dir : 0; p_draw = 0;
`ifdef WIN_CHECK_DRAW_EN
                    if (!w && board_full()) begin p_res = 1; p_draw = 1; end
`endif
                    m_busy = 1; m_left = e + 1;
                end else begin
                    m_done = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("busy",    int'(busy),         int'(m_busy));
                chk("done",    int'(done),         int'(m_done));
                chk("result",  int'(logic_result), int'(m_res));
                chk("winner",  int'(winner),       int'(m_win));
                chk("win_dir", int'(win_dir),      m_dir);
                chk("draw",    int'(draw),         int'(m_draw));
            end
        end
    end

    // ---------------- stimulus ----------------
    int s_h [8];
    logic [7:0] s_pl [8];

    task automatic wait_done(input int start, output int cyc);
        bit seen;
        seen = 0;
        cyc = start;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
            else begin cyc++; @(posedge clk); #1; end
        end
        if (!seen) begin chk("done_timeout", 0, 1); cyc = -1; end
        else begin @(posedge clk); #1; end
    endtask

    task automatic do_go(input int col, input logic [ROWS-1:0] on,
                         input logic [ROWS-1:0] pl, output int cyc);
        col_addr = 3'(col); onoff_col = on; player_col = pl; logic_go = 1'b1;
        @(posedge clk); #1;
        logic_go = 1'b0;
        wait_done(1, cyc);
    endtask

    task automatic place(input int col, input int p, output int cyc);
        logic [ROWS-1:0] on;
        if (col < int'(COLS)) begin
            if (s_h[col] < int'(ROWS)) begin
                s_pl[col][s_h[col]] = p[0];
                s_h[col]++;
            end
            on = ROWS'((1 << s_h[col]) - 1);
        end else begin
            on = ROWS'($urandom_range(1, (1 << ROWS) - 1));
        end
        do_go(col, on, s_pl[col][ROWS-1:0], cyc);
    endtask

    task automatic clear_board();
        logic_reset = 1'b1;
        @(posedge clk); #1;
        logic_reset = 1'b0;
        for (int c = 0; c < 8; c++) begin s_h[c] = 0; s_pl[c] = '0; end
    endtask

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        int cyc, seen, col, tot;
        for (int c = 0; c < 8; c++) begin s_h[c] = 0; s_pl[c] = '0; end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(logic_result), 0);
        chk("rst_win_dir", int'(win_dir), 0);
        @(posedge clk); #1;

        // Latency of an isolated disc.
        place(0, 0, cyc);
        chk("iso_latency", cyc, 10);
        chk("iso_result", int'(logic_result), 0);

        // Vertical win on column 3.
        clear_board();
        for (int i = 0; i < 3; i++) begin
            place(3, 0, cyc);
            chk("vert_partial", int'(logic_result), 0);
        end
        place(3, 0, cyc);
        chk("vert_latency", cyc, 8);
        chk("vert_result", int'(logic_result), 1);
        chk("vert_winner", int'(winner), 0);
        chk("vert_dir", int'(win_dir), 1);

        // Gap-fill horizontal win for player 1.
        clear_board();
        place(0, 1, cyc); place(1, 1, cyc); place(3, 1, cyc);
        place(2, 1, cyc);
        chk("gap_latency", cyc, 6);
        chk("gap_result", int'(logic_result), 1);
        chk("gap_winner", int'(winner), 1);
        chk("gap_dir", int'(win_dir), 0);

        // Blocked line, then completing it on the other end.
        clear_board();
        place(1, 0, cyc); place(2, 0, cyc); place(3, 0, cyc);
        place(4, 1, cyc);
        chk("block_result", int'(logic_result), 0);
        place(0, 0, cyc);
        chk("edge_latency", cyc, 5);
        chk("edge_result", int'(logic_result), 1);
        chk("edge_dir", int'(win_dir), 0);

        // Out-of-range column and empty column finish immediately.
        do_go(7, 6'b000001, 6'b000000, cyc);
        chk("badcol_latency", cyc, 1);
        chk("badcol_result", int'(logic_result), 0);
        do_go(5, 6'b000000, 6'b000000, cyc);
        chk("empty_latency", cyc, 1);

        // Abort mid-scan with logic_reset in cycle 4.
        clear_board();
        col_addr = 3'd0; onoff_col = 6'b000001; player_col = '0; logic_go = 1'b1;
        @(posedge clk); #1 logic_go = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        logic_reset = 1'b1;
        @(posedge clk); #1 logic_reset = 1'b0;
        seen = 0;
        repeat (12) begin @(negedge clk); if (done) seen++; end
        @(posedge clk); #1;
        chk("abort_no_done", seen, 0);
        do_go(1, 6'b000001, 6'b000000, cyc);
        chk("abort_board_empty", cyc, 10);

        // logic_go while busy is ignored.
        clear_board();
        col_addr = 3'd0; onoff_col = 6'b000001; player_col = '0; logic_go = 1'b1;
        @(posedge clk); #1 logic_go = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        col_addr = 3'd1; logic_go = 1'b1;
        @(posedge clk); #1 logic_go = 1'b0;
        wait_done(4, cyc);
        chk("busy_go_latency", cyc, 10);
        do_go(2, 6'b000001, 6'b000000, cyc);
        chk("busy_go_ignored", cyc, 10);

        // logic_reset beats a coincident logic_go.
        col_addr = 3'd0; onoff_col = 6'b000001; player_col = '0;
        logic_go = 1'b1; logic_reset = 1'b1;
        @(posedge clk); #1 logic_go = 1'b0; logic_reset = 1'b0;
        do_go(1, 6'b000001, 6'b000000, cyc);
        chk("prio_board_empty", cyc, 10);

        // Random play.
        clear_board();
        for (int m = 0; m < 250; m++) begin
            col = ($urandom_range(0, 19) == 0) ? 7 : int'($urandom_range(0, COLS - 1));
            place(col, int'($urandom_range(0, 1)), cyc);
            tot = 0;
            for (int c = 0; c < int'(COLS); c++) tot += s_h[c];
            if (m_res || tot == int'(COLS * ROWS)) clear_board();
        end

        // Full board in a pattern with no four-in-a-row anywhere.
        clear_board();
        for (int r = 0; r < int'(ROWS); r++)
            for (int c = 0; c < int'(COLS); c++)
                place(c, ((c / 2) + r) % 2, cyc);
`ifdef WIN_CHECK_DRAW_EN
        chk("draw_flag", int'(draw), 1);
        chk("draw_result", int'(logic_result), 1);
`else
        chk("draw_flag", int'(draw), 0);
        chk("draw_result", int'(logic_result), 0);
`endif
        chk("draw_winner", int'(winner), 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
